// File: rtl/apb_gpio_pkg.sv
// Shared register map, CONFIG field layout and interrupt types for the APB GPIO block.
package apb_gpio_pkg;

  localparam logic [7:0] CFG_BASE = 8'h00;
  localparam logic [7:0] IRQ_BASE = 8'h80;
  localparam logic [7:0] IN_BASE  = 8'h90;
  localparam logic [7:0] OUT_BASE = 8'hA0;

  localparam int CFG_OUT_EN       = 0;
  localparam int CFG_IN_EN        = 1;
  localparam int CFG_OE           = 2;
  localparam int CFG_INT_EN       = 3;
  localparam int CFG_INT_TYPE_LSB = 5;

  typedef enum logic [2:0] {
    INT_LEVEL_HIGH = 3'd0,
    INT_LEVEL_LOW  = 3'd1,
    INT_RISE       = 3'd2,
    INT_FALL       = 3'd3,
    INT_BOTH       = 3'd4
  } int_type_e;

  // io_type: 0 input, 1 output, 2 bidirectional; the reserved code 3 behaves as input.
  function automatic logic [7:0] fixed_cfg(input logic [1:0] io_type, input logic [2:0] int_type);
    logic [7:0] c;
    c = '0;
    c[CFG_INT_TYPE_LSB +: 3] = int_type;
    case (io_type)
      2'd1: begin
        c[CFG_OUT_EN] = 1'b1;
        c[CFG_OE]     = 1'b1;
      end
      2'd2: begin
        c[CFG_OUT_EN] = 1'b1;
        c[CFG_IN_EN]  = 1'b1;
        c[CFG_OE]     = 1'b1;
        c[CFG_INT_EN] = (int_type != 3'd7);
      end
      default: begin
        c[CFG_IN_EN]  = 1'b1;
        c[CFG_INT_EN] = (int_type != 3'd7);
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/gpio_bit_slice.sv
// One GPIO bit: CONFIG byte, input synchroniser, edge detect, sticky IRQ flop and output gating.
module gpio_bit_slice
  import apb_gpio_pkg::*;
#(
  parameter int         OE_TYPE   = 0,
  parameter bit         FIXED     = 1'b0,
  parameter logic [7:0] FIXED_CFG = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_we,
  input  logic [7:0] cfg_wd,
  input  logic       out_we,
  input  logic       out_wd,
  input  logic       irq_clr,
  input  logic       pad_in,
  output logic [7:0] cfg,
  output logic       out_q,
  output logic       in_q,
  output logic       irq,
  output logic       irq_next,
  output logic       gpio_out,
  output logic       gpio_oe
);

  logic sync1, sync2, sync2_dly;
  logic cond;

  if (FIXED) begin : g_fixed
    assign cfg = FIXED_CFG;
  end else begin : g_cfg_reg
    // NOTE: sequential state uses <= so every flop samples pre-edge values, whatever the block order.
    always_ff @(posedge clk) begin
      if (rst)         cfg <= '0;
      else if (cfg_we) cfg <= cfg_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync2_dly <= 1'b0;
      out_q     <= 1'b0;
      irq       <= 1'b0;
    end else begin
      sync1     <= pad_in;
      sync2     <= sync1;
      sync2_dly <= sync2;
      if (out_we) out_q <= out_wd;
      irq       <= irq_next;
    end
  end

  always_comb begin
    cond = 1'b0;
    case (int_type_e'(cfg[CFG_INT_TYPE_LSB +: 3]))
      INT_LEVEL_HIGH: cond = sync2;
      INT_LEVEL_LOW:  cond = ~sync2;
      INT_RISE:       cond = sync2 & ~sync2_dly;
      INT_FALL:       cond = ~sync2 & sync2_dly;
      INT_BOTH:       cond = sync2 ^ sync2_dly;
      default:        cond = 1'b0;
    endcase
  end

  // Set dominates clear, so a held level re-arms the flag immediately after a clear.
  assign irq_next = (cfg[CFG_INT_EN] & cond) | (irq & ~irq_clr);
  assign in_q     = sync2 & cfg[CFG_IN_EN];
  assign gpio_out = out_q & cfg[CFG_OUT_EN];
  assign gpio_oe  = (OE_TYPE == 1) ? cfg[CFG_OUT_EN] : cfg[CFG_OE];

endmodule

// File: rtl/apb_gpio_core.sv
// APB3 GPIO slave: address decode, lane steering and read mux around IO_NUM bit slices.
module apb_gpio_core
  import apb_gpio_pkg::*;
#(
  parameter int          IO_NUM       = 32,
  parameter int          APB_WIDTH    = 32,
  parameter int          OE_TYPE      = 0,
  parameter int          INT_BUS      = 1,
  parameter logic [31:0] FIXED_CONFIG = 32'h0,
  parameter logic [63:0] IO_TYPE      = 64'h0,
  parameter logic [95:0] IO_INT_TYPE  = 96'h0
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [7:0]           PADDR,
  input  logic [APB_WIDTH-1:0] PWDATA,
  output logic [APB_WIDTH-1:0] PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  input  logic [IO_NUM-1:0]    GPIO_IN,
  output logic [IO_NUM-1:0]    GPIO_OUT,
  output logic [IO_NUM-1:0]    GPIO_OE,
  output logic [IO_NUM-1:0]    INT,
  output logic                 INT_OR
);

  localparam int NLANES = 32 / APB_WIDTH;

  logic        wr_en, rd_en, word_ok, lane_ok;
  logic        hit_cfg, hit_irq, hit_in, hit_out;
  logic [31:0] wd_rep, lane_mask, out_we, irq_clr;
  logic [31:0] out32, in32, irq32, irq_next32, gpio_out32, gpio_oe32;
  logic [7:0]  cfg_all [32];
  logic [31:0] sel_word, rd_word;
  logic        int_or_q;

  assign wr_en   = PSEL & PENABLE & PWRITE;
  assign rd_en   = PSEL & ~PWRITE;
  assign word_ok = (PADDR[1:0] == 2'b00);
  assign lane_ok = int'(PADDR[3:2]) < NLANES;
  assign hit_cfg = word_ok && (PADDR[7] == CFG_BASE[7]) && (int'(PADDR[6:2]) < IO_NUM);
  assign hit_irq = word_ok && lane_ok && (PADDR[7:4] == IRQ_BASE[7:4]);
  assign hit_in  = word_ok && lane_ok && (PADDR[7:4] == IN_BASE[7:4]);
  assign hit_out = word_ok && lane_ok && (PADDR[7:4] == OUT_BASE[7:4]);

  // Each 32-bit register is viewed as NLANES bus-wide lanes selected by PADDR[3:2].
  assign wd_rep = {NLANES{PWDATA}};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < 32; b++) lane_mask[b] = ((b / APB_WIDTH) == int'(PADDR[3:2]));
  end

  assign out_we  = (wr_en && hit_out) ? lane_mask : '0;
  assign irq_clr = (wr_en && hit_irq) ? (lane_mask & wd_rep) : '0;

  for (genvar i = 0; i < 32; i++) begin : g_bit
    if (i < IO_NUM) begin : g_slice
      gpio_bit_slice #(
        .OE_TYPE  (OE_TYPE),
        .FIXED    (FIXED_CONFIG[i]),
        .FIXED_CFG(fixed_cfg(IO_TYPE[2*i +: 2], IO_INT_TYPE[3*i +: 3]))
      ) u_slice (
        .clk     (PCLK),
        .rst     (PRESET),
        .cfg_we  (wr_en && hit_cfg && (PADDR[6:2] == 5'(i))),
        .cfg_wd  (PWDATA[7:0]),
        .out_we  (out_we[i]),
        .out_wd  (wd_rep[i]),
        .irq_clr (irq_clr[i]),
        .pad_in  (GPIO_IN[i]),
        .cfg     (cfg_all[i]),
        .out_q   (out32[i]),
        .in_q    (in32[i]),
        .irq     (irq32[i]),
        .irq_next(irq_next32[i]),
        .gpio_out(gpio_out32[i]),
        .gpio_oe (gpio_oe32[i])
      );
    end else begin : g_pad
      assign cfg_all[i]    = '0;
      assign out32[i]      = 1'b0;
      assign in32[i]       = 1'b0;
      assign irq32[i]      = 1'b0;
      assign irq_next32[i] = 1'b0;
      assign gpio_out32[i] = 1'b0;
      assign gpio_oe32[i]  = 1'b0;
    end
  end

  // Loaded from the next IRQ state so INT_OR changes on the same edge as INT.
  always_ff @(posedge PCLK) begin
    if (PRESET) int_or_q <= 1'b0;
    else        int_or_q <= |irq_next32;
  end

  always_comb begin
    sel_word = '0;
    if (hit_cfg)      sel_word = {24'h0, cfg_all[PADDR[6:2]]};
    else if (hit_irq) sel_word = irq32 >> (int'(PADDR[3:2]) * APB_WIDTH);
    else if (hit_in)  sel_word = in32 >> (int'(PADDR[3:2]) * APB_WIDTH);
    else if (hit_out) sel_word = out32 >> (int'(PADDR[3:2]) * APB_WIDTH);
  end

  assign rd_word  = rd_en ? sel_word : '0;
  assign PRDATA   = rd_word[APB_WIDTH-1:0];
  assign PREADY   = 1'b1;
  assign PSLVERR  = 1'b0;
  assign GPIO_OUT = gpio_out32[IO_NUM-1:0];
  assign GPIO_OE  = gpio_oe32[IO_NUM-1:0];
  assign INT      = (INT_BUS != 0) ? irq32[IO_NUM-1:0] : '0;
  assign INT_OR   = int_or_q;

endmodule

// File: tb/tb_apb_gpio_core.sv
// Directed bench for apb_gpio_core: a 32-bit default build plus a 16-bit-wide-GPIO, 8-bit-bus build.
module tb_apb_gpio_core;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        psel = 1'b0, psel8 = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] gpio_in = '0;

  logic [31:0] prdata, gpio_out, gpio_oe, int_vec;
  logic        pready, pslverr, int_or;
  logic [7:0]  prdata8;
  logic [15:0] gpio_out8, gpio_oe8, int_vec8;
  logic        pready8, pslverr8, int_or8;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  always #5 pclk = ~pclk;

  apb_gpio_core dut (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
    .GPIO_IN(gpio_in), .GPIO_OUT(gpio_out), .GPIO_OE(gpio_oe), .INT(int_vec), .INT_OR(int_or)
  );

  apb_gpio_core #(
    .IO_NUM(16), .APB_WIDTH(8), .FIXED_CONFIG(32'h1), .IO_TYPE(64'h1)
  ) dut8 (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel8), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata[7:0]), .PRDATA(prdata8), .PREADY(pready8), .PSLVERR(pslverr8),
    .GPIO_IN(gpio_in[15:0]), .GPIO_OUT(gpio_out8), .GPIO_OE(gpio_oe8), .INT(int_vec8), .INT_OR(int_or8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input bit w8, input logic [7:0] addr, input logic [31:0] data);
    psel = !w8; psel8 = w8; pwrite = 1'b1; paddr = addr; pwdata = data; penable = 1'b0;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1 psel = 1'b0; psel8 = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input bit w8, input logic [7:0] addr, output logic [31:0] data);
    psel = !w8; psel8 = w8; pwrite = 1'b0; paddr = addr; penable = 1'b0;
    @(posedge pclk); #1 penable = 1'b1;
    #1 data = w8 ? {24'h0, prdata8} : prdata;
    @(posedge pclk); #1 psel = 1'b0; psel8 = 1'b0; penable = 1'b0;
  endtask

  task automatic check_read(input bit w8, input logic [7:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    apb_read(w8, addr, d);
    check(tag, d, exp);
  endtask

  initial begin
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;

    // Reset state
    check("idle_prdata", prdata, 32'h0);
    check("pready", {31'h0, pready}, 32'h1);
    check("pslverr", {31'h0, pslverr}, 32'h0);
    check("rst_gpio_out", gpio_out, 32'h0);
    check("rst_gpio_oe", gpio_oe, 32'h0);
    check("rst_int", int_vec, 32'h0);
    check("rst_int_or", {31'h0, int_or}, 32'h0);
    for (int i = 0; i < 32; i++) check_read(0, 8'(4 * i), 32'h0, $sformatf("rst_cfg%0d", i));
    check_read(0, 8'h80, 32'h0, "rst_irq");
    check_read(0, 8'hA0, 32'h0, "rst_out");

    // Output path: OUT stored as written, pads gated by OUT_EN
    apb_write(0, 8'h0C, 32'h05);
    apb_write(0, 8'hA0, 32'hFFFF_0008);
    check("out_gated", gpio_out, 32'h8);
    check("oe_bit3", gpio_oe, 32'h8);
    check_read(0, 8'hA0, 32'hFFFF_0008, "out_readback");
    check_read(0, 8'h0C, 32'h05, "cfg3_readback");

    // Input path: visible exactly two edges after the pad changes
    apb_write(0, 8'h14, 32'h02);
    gpio_in = 32'h20;
    @(posedge pclk); #1;
    check_read(0, 8'h90, 32'h20, "in_after_2_edges");
    gpio_in = 32'h0;
    check_read(0, 8'h90, 32'h20, "in_still_old_after_1_edge");
    check_read(0, 8'h90, 32'h0, "in_fell");
    gpio_in = 32'h20;
    apb_write(0, 8'h14, 32'h00);
    check_read(0, 8'h90, 32'h0, "in_masked_by_in_en");

    // Rising-edge interrupt on bit 7
    apb_write(0, 8'h1C, 32'h4A);
    gpio_in = 32'hA0;
    repeat (2) @(posedge pclk); #1;
    check("rise_not_yet", int_vec, 32'h0);
    @(posedge pclk); #1;
    check("rise_int", int_vec, 32'h80);
    check("rise_int_or", {31'h0, int_or}, 32'h1);
    check_read(0, 8'h80, 32'h80, "rise_irq_read");
    apb_write(0, 8'h80, 32'h80);
    check("rise_cleared", int_vec, 32'h0);
    check("rise_cleared_or", {31'h0, int_or}, 32'h0);
    repeat (4) @(posedge pclk); #1;
    check("rise_stays_clear", int_vec, 32'h0);

    // Falling-edge interrupt on bit 9
    apb_write(0, 8'h24, 32'h6A);
    gpio_in = 32'h2A0;
    repeat (4) @(posedge pclk); #1;
    check("fall_ignores_rise", int_vec, 32'h0);
    gpio_in = 32'hA0;
    repeat (3) @(posedge pclk); #1;
    check("fall_int", int_vec, 32'h200);
    apb_write(0, 8'h80, 32'h200);
    check("fall_cleared", int_vec, 32'h0);

    // Level-high interrupt on bit 2: set wins over clear while the level holds
    apb_write(0, 8'h08, 32'h0A);
    gpio_in = 32'hA4;
    repeat (4) @(posedge pclk); #1;
    check("level_int", int_vec, 32'h04);
    check("level_int_or", {31'h0, int_or}, 32'h1);
    apb_write(0, 8'h80, 32'h04);
    check("level_set_wins", int_vec, 32'h04);
    gpio_in = 32'hA0;
    repeat (4) @(posedge pclk); #1;
    check("level_sticky", int_vec, 32'h04);
    apb_write(0, 8'h80, 32'h04);
    check("level_cleared", int_vec, 32'h0);
    check("level_cleared_or", {31'h0, int_or}, 32'h0);

    // Unmapped and misaligned accesses
    apb_write(0, 8'hB0, 32'hFFFF_FFFF);
    apb_write(0, 8'hA4, 32'h0000_1234);
    check_read(0, 8'hA0, 32'hFFFF_0008, "unmapped_write_ignored");
    check_read(0, 8'hB0, 32'h0, "unmapped_read");
    check_read(0, 8'h0D, 32'h0, "misaligned_read");

    // Reset during the access phase aborts the write
    psel = 1'b1; pwrite = 1'b1; paddr = 8'hA0; pwdata = 32'h55; penable = 1'b0;
    @(posedge pclk); #1 penable = 1'b1; preset = 1'b1;
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0; preset = 1'b0;
    check("midrst_gpio_out", gpio_out, 32'h0);
    check("midrst_gpio_oe", gpio_oe, 32'h0);
    check("midrst_int", int_vec, 32'h0);
    check_read(0, 8'hA0, 32'h0, "midrst_out");
    check_read(0, 8'h0C, 32'h0, "midrst_cfg3");

    // 8-bit bus, 16 GPIOs, bit 0 fixed as output
    check("w8_fixed_oe", {16'h0, gpio_oe8}, 32'h0001);
    check_read(1, 8'h00, 32'h05, "w8_fixed_cfg0");
    apb_write(1, 8'h00, 32'h00);
    check_read(1, 8'h00, 32'h05, "w8_fixed_cfg0_write_ignored");
    for (int i = 8; i < 16; i++) apb_write(1, 8'(4 * i), 32'h01);
    apb_write(1, 8'hA4, 32'hA5);
    check("w8_out_byte1", {16'h0, gpio_out8}, 32'hA500);
    check_read(1, 8'hA4, 32'hA5, "w8_read_a4");
    check_read(1, 8'hA0, 32'h00, "w8_read_a0_untouched");
    apb_write(1, 8'hA0, 32'hFF);
    check("w8_out_byte0_gated", {16'h0, gpio_out8}, 32'hA501);
    check_read(1, 8'hA0, 32'hFF, "w8_read_a0");
    apb_write(1, 8'hA8, 32'hFF);
    check_read(1, 8'hA8, 32'h00, "w8_lane_beyond_io_num");
    check_read(1, 8'h40, 32'h00, "w8_cfg16_beyond_io_num");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_gpio_core.md
Name: apb_gpio_core

Overview:
- Configurable APB3 slave GPIO block with up to 32 bits, per-bit configuration, input synchronisation, output/OE registers and per-bit interrupt generation.
- Sits on a processor APB bus and drives pads or a pad wrapper.
- Interrupts are presented as a per-bit vector plus a single OR-reduced line.

Parameters:
- IO_NUM, 32, number of GPIO bits, 1..32.
- APB_WIDTH, 32, APB data width; 8, 16 or 32.
- OE_TYPE, 0, 0 = GPIO_OE per bit from CONFIG bit2; 1 = GPIO_OE per bit = CONFIG bit0 (output enable).
- INT_BUS, 1, 1 = INT vector driven; 0 = INT tied to 0 and only INT_OR is active.
- FIXED_CONFIG, 32'h0, bit i = 1 makes CONFIG_i a constant built from IO_TYPE/IO_INT_TYPE; APB writes to it are ignored.
- IO_TYPE, 64'h0, 2 bits per GPIO: 0 = input (cfg 8'h0A-style: IN_EN), 1 = output (OUT_EN|OE), 2 = both (OUT_EN|IN_EN|OE). Used only when fixed.
- IO_INT_TYPE, 96'h0, 3 bits per GPIO, interrupt type for fixed bits. Interrupt enable is set for input/both types whenever the type is not 7 (7 = disabled).

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  synchronous, active-high reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  APB write.
- PADDR  in  8  byte address.
- PWDATA  in  APB_WIDTH  write data.
- PRDATA  out  APB_WIDTH  read data.
- PREADY  out  1  constant 1.
- PSLVERR  out  1  constant 0.
- GPIO_IN  in  IO_NUM  pad inputs (asynchronous).
- GPIO_OUT  out  IO_NUM  output values.
- GPIO_OE  out  IO_NUM  output enables.
- INT  out  IO_NUM  per-bit interrupt.
- INT_OR  out  1  OR of all IRQ bits.

Behaviour:
- APB timing:
  - Write takes effect on the PCLK edge where PSEL & PENABLE & PWRITE = 1.
  - No wait states.
  - PRDATA is combinational from PADDR while PSEL = 1 and !PWRITE; otherwise 0.
  - Unmapped addresses read 0; writes to them are ignored.
- Register map:
  - CONFIG_i at 0x00 + 4i (8 bits, zero-extended on read). Fields: bit0 OUT_EN, bit1 IN_EN, bit2 OE, bit3 INT_EN, bits7:5 INT_TYPE. INT_TYPE: 0 level-high, 1 level-low, 2 rising, 3 falling, 4 both edges, others none.
  - IRQ at 0x80.
  - IN at 0x90 (read-only).
  - OUT at 0xA0.
  - APB_WIDTH = 16: upper half of IRQ/IN/OUT at base + 0x04.
  - APB_WIDTH = 8: byte k at base + 4k.
  - Lanes beyond IO_NUM read 0.
- Input path:
  - GPIO_IN passes through a 2-flop synchroniser (sync2).
  - IN[i] = sync2[i] & IN_EN[i].
  - Latency: GPIO_IN change becomes visible in IN after 2 PCLK edges.
- Output path:
  - GPIO_OUT[i] = OUTREG[i] & OUT_EN[i].
  - GPIO_OE per OE_TYPE.
  - OUTREG is written via OUT and reads back as stored.
- Interrupts:
  - Edge detection compares sync2 with a one-cycle-delayed copy.
  - IRQ[i] is set in a cycle where INT_EN[i] is set and the selected condition is true.
  - Writing 1 to an IRQ bit clears it; writing 0 has no effect.
  - If set and clear occur in the same cycle, set wins. As a result, level interrupts persist while the level holds.
  - INT = IRQ (when INT_BUS = 1). INT_OR = |IRQ. Both are registered outputs.
- Reset (PRESET = 1 at a PCLK edge):
  - Non-fixed CONFIG, OUTREG, IRQ, sync2 and the delayed copy all go to 0.
  - All outputs go to 0, except fixed CONFIG-derived values and PREADY = 1.
  - Reset mid-transfer aborts the write.

Decomposition:
- Package apb_gpio_pkg:
  - Register offset constants (CFG_BASE, IRQ_BASE, IN_BASE, OUT_BASE).
  - CONFIG field bit positions.
  - INT_TYPE enumeration.
  - Function that builds a fixed config byte from IO_TYPE/IO_INT_TYPE.
- One natural sub-module: gpio_bit_slice.
  - Contains one bit's CONFIG register, sync, edge detect, IRQ flop and output gating.
  - Generated IO_NUM times.
  - Top level holds APB decode and read mux.

Test Plan:
- Reset, then read CONFIG_0..31, IRQ, OUT -> all 0; PREADY = 1, PSLVERR = 0.
- Write CONFIG_3 = 0x05 and OUT = 0x0000_0008 -> GPIO_OUT = 0x8 and GPIO_OE[3] = 1 one cycle after the write; read OUT = 0x8.
- Write CONFIG_5 = 0x02 and drive GPIO_IN = 0x20 -> read IN = 0x20 after 2 edges. With CONFIG_5 = 0x00, read IN = 0x0.
- CONFIG_7 = 0x4A (rising edge, INT_EN, IN_EN), then pulse GPIO_IN[7] 0->1:
  - INT[7] = 1 and INT_OR = 1.
  - Write IRQ = 0x80 -> INT[7] = 0 and stays 0 while the input holds high.
- CONFIG_2 = 0x0A (level-high), GPIO_IN[2] held at 1; write IRQ = 0x04 -> INT[2] remains 1. Drop input, write again -> INT[2] = 0.
- APB_WIDTH = 8 build: write 0xA5 to 0xA4 -> GPIO_OUT[15:8] = 0xA5 (OUT_EN set); read 0xA4 = 0xA5; read 0xA0 unaffected.
